truth_table_checker: RTL and testbench
======================================

Name: truth_table_checker

Overview:
- Response-side counterpart to our exhaustive truth-table stimulus benches: a synthesizable checker that receives (input vector, DUT output) pairs over a valid/ready handshake.
- Each accepted output is compared against an expected truth table, and the block tracks which vectors have been covered.
- It accumulates a mismatch count and the first failing vector, then flags done/pass once all 2^N_IN combinations have been seen.
- It sits between a lab DUT (e.g. the E1/E2 logic functions) and the board LEDs / bench monitor.

Parameters:
- N_IN, 4, number of DUT inputs; the table has 2^N_IN entries.
- EXP_TT, 16'hA5C3, expected output table; bit i is the expected Y for input vector i. Width is 2^N_IN.
- CNT_W, N_IN+1, width of the mismatch counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new check and clears statistics.
- in_valid  in  1  pair presented on in_vec/in_y.
- in_ready  out  1  checker accepts a pair this cycle.
- in_vec  in  N_IN  input vector applied to the DUT.
- in_y  in  1  DUT output for in_vec.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  done and err_cnt==0.
- err_cnt  out  CNT_W  number of mismatches, saturating.
- first_fail  out  N_IN  vector of the first mismatch.
- first_fail_vld  out  1  first_fail holds a valid value.
- coverage  out  2^N_IN  bit i set once vector i has been accepted.

Behaviour:
- Reset (async, any state): state=IDLE, and every output is 0 (in_ready, busy, done, pass, err_cnt, first_fail, first_fail_vld, coverage).
- All outputs are registered or decoded from registered state only; there is no combinational path from in_* to any output.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=0.
  - start=1 clears coverage, err_cnt, first_fail and first_fail_vld, then moves to RUN at the next edge.
- RUN:
  - busy=1 and in_ready=1.
  - Accept happens when in_valid && in_ready at a rising edge. On accept:
    - coverage[in_vec] is set to 1.
    - mismatch = in_y != EXP_TT[in_vec].
    - On mismatch, err_cnt increments and saturates at 2^CNT_W-1 (no wrap).
    - On mismatch with first_fail_vld=0, first_fail=in_vec and first_fail_vld=1. Later mismatches never overwrite it.
  - Duplicate vectors (coverage bit already set) are still checked and counted; coverage is unchanged.
  - in_valid=0 gaps: no state change.
  - start in RUN is ignored.
  - Transition to DONE happens at the same edge where the updated coverage becomes all ones. done is therefore visible in the cycle after the last new vector is accepted (latency 1), and in_ready is already 0 that cycle.
- DONE:
  - done=1, busy=0, in_ready=0; pass=(err_cnt==0).
  - All statistics hold.
  - start=1 clears the statistics and moves to RUN, as from IDLE.
- Reset mid-run: all statistics are lost and the block returns to IDLE. A pair presented in the reset cycle is not accepted.
- X/Z on in_y during accept counts as a mismatch (compare with !==).

Test Plan:
- Reset, start, then vectors 0..15 in order with in_y=EXP_TT[i], one per cycle -> done=1 exactly one cycle after the 16th accept, pass=1, err_cnt=0, first_fail_vld=0, coverage=16'hFFFF.
- Same sweep with in_y inverted at vectors 5 and 9 -> err_cnt=2, first_fail=5, first_fail_vld=1, pass=0, done=1.
- Order 15..0 with vector 3 sent three times and in_valid gaps of 2 cycles -> done only after all 16 distinct vectors; coverage goes 16'hFFFF at that point; duplicates produce no error when in_y is correct.
- All 16 vectors wrong, plus 20 extra wrong duplicates of vector 0 (N_IN=4, CNT_W=5) -> err_cnt saturates at 31; first_fail equals the first vector sent.
- Assert reset after 7 accepts -> all outputs 0 immediately (async); state IDLE; in_ready=0 until the next start.
- In DONE with err_cnt=2, pulse start -> next cycle busy=1, err_cnt=0, coverage=0, first_fail_vld=0; a start pulse during RUN has no effect.

Source files
------------

// File: rtl/truth_table_checker.sv
// truth_table_checker: compares (vector, DUT output) pairs against an expected truth table,
// tracking coverage, a saturating mismatch count and the first failing vector.
module truth_table_checker #(
    parameter int                    N_IN   = 4,
    parameter logic [2**N_IN-1:0]    EXP_TT = 16'hA5C3,
    parameter int                    CNT_W  = N_IN + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_IN-1:0]      in_vec,
    input  logic                 in_y,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [N_IN-1:0]      first_fail,
    output logic                 first_fail_vld,
    output logic [2**N_IN-1:0]   coverage
);
    localparam int NV = 2**N_IN;
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    logic [1:0]    state;
    logic          accept, mismatch;
    logic [NV-1:0] oneHot, covNext;
    assign in_ready = state == RUN;
    assign busy     = state == RUN;
    assign done     = state == DONE;
    assign pass     = done && err_cnt == '0;
    assign accept   = in_valid && in_ready;
    // X/Z on in_y must count as a mismatch, hence the 4-state compare
    assign mismatch = in_y !== EXP_TT[in_vec];
    assign oneHot   = NV'(1) << in_vec;
    assign covNext  = coverage | oneHot;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            err_cnt        <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
            coverage       <= '0;
        end else if (state != RUN) begin
            if (start) begin
                state          <= RUN;
                err_cnt        <= '0;
                first_fail     <= '0;
                first_fail_vld <= 1'b0;
                coverage       <= '0;
            end
        end else if (accept) begin
            coverage <= covNext;
            if (&covNext) state <= DONE;
            if (mismatch) begin
                if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                if (!first_fail_vld) begin
                    first_fail     <= in_vec;
                    first_fail_vld <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker: directed-vector bench for truth_table_checker.
module tb_truth_table_checker;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_vec = '0;
    logic        in_y = 1'b0;
    logic        in_ready, busy, done, pass, first_fail_vld;
    logic [4:0]  err_cnt;
    logic [3:0]  first_fail;
    logic [15:0] coverage;
    logic [15:0] tt = 16'hA5C3;
    int total = 0;
    int bad = 0;

    truth_table_checker #(.N_IN(4), .EXP_TT(16'hA5C3), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_vec(in_vec), .in_y(in_y), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_fail(first_fail), .first_fail_vld(first_fail_vld),
        .coverage(coverage)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int v, input logic y);
        in_valid = 1'b1;
        in_vec   = 4'(v);
        in_y     = y;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_ffv", first_fail_vld, 0);
        chk("rst_cov", coverage, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("idle_ready", in_ready, 0);
        pulse_start();
        chk("run_busy", busy, 1);
        chk("run_ready", in_ready, 1);

        // clean ascending sweep
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("t1_not_done_early", done, 0);
            send(i, tt[i]);
        end
        chk("t1_done", done, 1);
        chk("t1_ready", in_ready, 0);
        chk("t1_busy", busy, 0);
        chk("t1_pass", pass, 1);
        chk("t1_err", err_cnt, 0);
        chk("t1_ffv", first_fail_vld, 0);
        chk("t1_cov", coverage, 16'hFFFF);

        // sweep with errors at 5 and 9
        pulse_start();
        for (int i = 0; i < 16; i++) send(i, (i == 5 || i == 9) ? ~tt[i] : tt[i]);
        chk("t2_done", done, 1);
        chk("t2_err", err_cnt, 2);
        chk("t2_ff", first_fail, 5);
        chk("t2_ffv", first_fail_vld, 1);
        chk("t2_pass", pass, 0);

        // restart from DONE clears statistics
        pulse_start();
        chk("t6_busy", busy, 1);
        chk("t6_err", err_cnt, 0);
        chk("t6_cov", coverage, 0);
        chk("t6_ffv", first_fail_vld, 0);
        send(2, ~tt[2]);
        send(4, tt[4]);
        pulse_start();
        chk("t6_start_in_run_err", err_cnt, 1);
        chk("t6_start_in_run_cov", coverage, 16'h0014);
        chk("t6_start_in_run_ff", first_fail, 2);
        for (int i = 6; i < 11; i++) send(i, tt[i]);
        chk("t5_cov7", coverage, 16'h07D4);

        // async reset mid-run, pair held valid through the reset
        in_valid = 1'b1;
        in_vec   = 4'd0;
        in_y     = ~tt[0];
        #2 reset = 1'b1;
        #1;
        chk("t5_err", err_cnt, 0);
        chk("t5_cov", coverage, 0);
        chk("t5_ffv", first_fail_vld, 0);
        chk("t5_ff", first_fail, 0);
        chk("t5_busy", busy, 0);
        chk("t5_ready", in_ready, 0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        in_valid = 1'b0;
        chk("t5_idle_ready", in_ready, 0);
        chk("t5_idle_cov", coverage, 0);
        chk("t5_idle_err", err_cnt, 0);

        // descending with triple vector 3 and 2-cycle gaps
        pulse_start();
        for (int i = 15; i >= 0; i--) begin
            int reps = (i == 3) ? 3 : 1;
            for (int r = 0; r < reps; r++) begin
                if (i == 0) begin
                    chk("t3_not_done", done, 0);
                    chk("t3_cov_pre", coverage, 16'hFFFE);
                end
                send(i, tt[i]);
                if (i != 0) begin
                    tick();
                    tick();
                end
            end
        end
        chk("t3_done", done, 1);
        chk("t3_cov", coverage, 16'hFFFF);
        chk("t3_err", err_cnt, 0);
        chk("t3_pass", pass, 1);

        // saturation: 21 wrong vector-0 pairs then 15 more wrong
        pulse_start();
        for (int r = 0; r < 21; r++) send(0, ~tt[0]);
        chk("t4_err21", err_cnt, 21);
        chk("t4_busy", busy, 1);
        for (int i = 1; i < 16; i++) send(i, ~tt[i]);
        chk("t4_err_sat", err_cnt, 31);
        chk("t4_ff", first_fail, 0);
        chk("t4_ffv", first_fail_vld, 1);
        chk("t4_done", done, 1);
        chk("t4_pass", pass, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
